// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the RV32I ALU: decodes OP/OP-IMM/LUI/AUIPC, forwards from execute,
// and holds one instruction behind a valid/ready handshake. ISSUE_PERF_CNT_EN adds perf counters.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] ex_result,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_func,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  typedef enum logic [3:0] {
    FN_ADD  = 4'b0000,
    FN_SUB  = 4'b0001,
    FN_SLL  = 4'b0010,
    FN_SRL  = 4'b0011,
    FN_SLTU = 4'b0100,
    FN_AND  = 4'b0101,
    FN_OR   = 4'b0110,
    FN_XOR  = 4'b0111,
    FN_SRA  = 4'b1000,
    FN_SLT  = 4'b1001,
    FN_PASSB = 4'b1011
  } alu_func_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  alu_func_e       func_q, func_d;
  logic [4:0]      rd_q, rd_d;
  logic            wb_en_q, wb_en_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] imm_i, imm_u, shamt;
  logic [XLEN-1:0] src1, src2;
  logic            fwd1, fwd2;
  logic            capture;
  logic            dec_ill;
  alu_func_e       dec_func, base_func;
  logic [XLEN-1:0] dec_a, dec_b;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    opcode  = in_instr[6:0];
    rd_idx  = in_instr[11:7];
    funct3  = in_instr[14:12];
    rs1_idx = in_instr[19:15];
    rs2_idx = in_instr[24:20];
    funct7  = in_instr[31:25];
    imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_u   = {in_instr[31:12], 12'b0};
    shamt   = {27'b0, in_instr[24:20]};

    // The instruction held here is the one the ALU is executing this cycle.
    fwd1 = valid_q && wb_en_q && (rd_q != '0) && (rd_q == rs1_idx);
    fwd2 = valid_q && wb_en_q && (rd_q != '0) && (rd_q == rs2_idx);
    src1 = fwd1 ? ex_result : rs1_data;
    src2 = fwd2 ? ex_result : rs2_data;

    unique case (funct3)
      3'b000:  base_func = FN_ADD;
      3'b001:  base_func = FN_SLL;
      3'b010:  base_func = FN_SLT;
      3'b011:  base_func = FN_SLTU;
      3'b100:  base_func = FN_XOR;
      3'b101:  base_func = FN_SRL;
      3'b110:  base_func = FN_OR;
      default: base_func = FN_AND;
    endcase

    dec_ill  = 1'b1;
    dec_func = FN_ADD;
    dec_a    = '0;
    dec_b    = '0;
    case (opcode)
      OPC_OP: begin
        dec_a    = src1;
        dec_b    = src2;
        dec_func = base_func;
        if (funct7 == 7'b0000000) begin
          dec_ill = 1'b0;
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_ill  = 1'b0;
          dec_func = (funct3 == 3'b000) ? FN_SUB : FN_SRA;
        end
      end
      OPC_OP_IMM: begin
        dec_a    = src1;
        dec_b    = imm_i;
        dec_func = base_func;
        dec_ill  = 1'b0;
        if (funct3 == 3'b001) begin
          dec_b   = shamt;
          dec_ill = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_b = shamt;
          if (funct7 == 7'b0100000) begin
            dec_func = FN_SRA;
          end else begin
            dec_ill = (funct7 != 7'b0000000);
          end
        end
      end
      OPC_LUI: begin
        dec_ill  = 1'b0;
        dec_b    = imm_u;
        dec_func = FN_PASSB;
      end
      OPC_AUIPC: begin
        dec_ill = 1'b0;
        dec_a   = in_pc;
        dec_b   = imm_u;
      end
      default: ;
    endcase
    if (dec_ill) begin
      dec_func = FN_ADD;
      dec_a    = '0;
      dec_b    = '0;
    end

    if (flush)         valid_d = 1'b0;
    else if (capture)  valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    else               valid_d = valid_q;

    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    rd_d      = rd_q;
    wb_en_d   = wb_en_q;
    illegal_d = illegal_q;
    if (capture) begin
      a_d       = dec_a;
      b_d       = dec_b;
      func_d    = dec_func;
      rd_d      = rd_idx;
      wb_en_d   = !dec_ill && (rd_idx != '0);
      illegal_d = dec_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= FN_ADD;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_func    = func_q;
  assign out_rd      = rd_q;
  assign out_wb_en   = wb_en_q;
  assign out_illegal = illegal_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issued_q, issued_d, stall_q, stall_d;

  always_comb begin
    issued_d = issued_q + 32'(capture);
    stall_d  = stall_q + 32'(in_valid && !in_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected issues are queued at drive time and
// compared as each one retires; directed checks cover stall, flush and async reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] ex_result = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_func;
  logic [4:0]  out_rd;
  logic        out_wb_en, out_illegal;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .out_illegal(out_illegal)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  f;
    logic [4:0]  rd;
    logic        wb, ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_issued = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Each held instruction is seen at exactly one negedge with out_ready high before it retires.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_issue", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("alu_a", alu_a, e.a);
        check_eq("alu_b", alu_b, e.b);
        check_eq("alu_func", 32'(alu_func), 32'(e.f));
        check_eq("out_rd", 32'(out_rd), 32'(e.rd));
        check_eq("out_wb_en", 32'(out_wb_en), 32'(e.wb));
        check_eq("out_illegal", 32'(out_illegal), 32'(e.ill));
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, b, input logic [3:0] f, input logic [4:0] rd,
                          input logic wb, ill);
    exp_t e;
    e.a = a; e.b = b; e.f = f; e.rd = rd; e.wb = wb; e.ill = ill;
    sb.push_back(e);
  endtask

  // Drives one instruction for one edge with out_ready high (so in_ready is high).
  task automatic issue_instr(input logic [31:0] instr, pc, r1, r2, exr,
                             input logic [31:0] ea, eb, input logic [3:0] ef,
                             input logic [4:0] erd, input logic ewb, eill);
    push_exp(ea, eb, ef, erd, ewb, eill);
    in_instr  = instr;
    in_pc     = pc;
    rs1_data  = r1;
    rs2_data  = r2;
    ex_result = exr;
    in_valid  = 1'b1;
    exp_issued++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_a"}, alu_a, 32'd0);
    check_eq({tag, "_b"}, alu_b, 32'd0);
    check_eq({tag, "_func"}, 32'(alu_func), 32'd0);
    check_eq({tag, "_rd"}, 32'(out_rd), 32'd0);
    check_eq({tag, "_wb"}, 32'(out_wb_en), 32'd0);
    check_eq({tag, "_ill"}, 32'(out_illegal), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef ISSUE_PERF_CNT_EN
    check_eq("reset_perf_issued", perf_issued, 32'd0);
    check_eq("reset_perf_stall", perf_stall, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // instr, pc, rs1, rs2, ex_result | a, b, func, rd, wb, ill
    issue_instr(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0,            32'h0, 32'h5, 4'h0, 5'd1, 1'b1, 1'b0);
    issue_instr(32'h00108133, 32'h4, 32'hDEAD0001, 32'hDEAD0002, 32'h5,
                32'h5, 32'h5, 4'h0, 5'd2, 1'b1, 1'b0);
    issue_instr(32'h40325193, 32'h8, 32'h80000000, 32'h9, 32'h55,
                32'h80000000, 32'h3, 4'h8, 5'd3, 1'b1, 1'b0);
    issue_instr(32'h02325193, 32'hC, 32'h80000000, 32'h9, 32'h55,
                32'h0, 32'h0, 4'h0, 5'd3, 1'b0, 1'b1);
    issue_instr(32'h123452B7, 32'h10, 32'hAAAA, 32'hBBBB, 32'hCCCC,
                32'h0, 32'h12345000, 4'hB, 5'd5, 1'b1, 1'b0);
    issue_instr(32'h00001317, 32'h100, 32'hAAAA, 32'hBBBB, 32'hCCCC,
                32'h100, 32'h1000, 4'h0, 5'd6, 1'b1, 1'b0);
    issue_instr(32'h000303B7, 32'h104, 32'hAAAA, 32'hBBBB, 32'hCAFE,
                32'h0, 32'h30000, 4'hB, 5'd7, 1'b1, 1'b0);
    issue_instr(32'h409403B3, 32'h108, 32'd10, 32'd3, 32'hCAFE,
                32'd10, 32'd3, 4'h1, 5'd7, 1'b1, 1'b0);
    issue_instr(32'hFFF0B413, 32'h10C, 32'h1234, 32'h0, 32'hCAFE,
                32'h1234, 32'hFFFFFFFF, 4'h4, 5'd8, 1'b1, 1'b0);
    issue_instr(32'h00208033, 32'h110, 32'h1, 32'h2, 32'hCAFE,
                32'h1, 32'h2, 4'h0, 5'd0, 1'b0, 1'b0);
    issue_instr(32'h000004B3, 32'h114, 32'h11, 32'h22, 32'h99,
                32'h11, 32'h22, 4'h0, 5'd9, 1'b1, 1'b0);
    issue_instr(32'h0014C533, 32'h118, 32'h1, 32'h44, 32'h77,
                32'h77, 32'h44, 4'h7, 5'd10, 1'b1, 1'b0);
    issue_instr(32'h00A615B3, 32'h11C, 32'h5, 32'h6, 32'h3,
                32'h5, 32'h3, 4'h2, 5'd11, 1'b1, 1'b0);
    issue_instr(32'hFFFFFFFF, 32'h120, 32'h5, 32'h6, 32'h3,
                32'h0, 32'h0, 4'h0, 5'd31, 1'b0, 1'b1);

    // Stall: lui held for 3 edges while the next instruction waits.
    issue_instr(32'h123452B7, 32'h200, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h12345000, 4'hB, 5'd5, 1'b1, 1'b0);
    out_ready = 1'b0;
    push_exp(32'd10, 32'd3, 4'h1, 5'd7, 1'b1, 1'b0);
    in_instr = 32'h409403B3; rs1_data = 32'd10; rs2_data = 32'd3; ex_result = 32'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_b", alu_b, 32'h12345000);
      check_eq("stall_func", 32'(alu_func), 32'hB);
      check_eq("stall_rd", 32'(out_rd), 32'd5);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    exp_issued++;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef ISSUE_PERF_CNT_EN
    check_eq("perf_stall", perf_stall, 32'd3);
    check_eq("perf_issued", perf_issued, 32'(exp_issued));
`endif
    @(posedge clk); #1;

    // Flush with a held instruction and an incoming one, retire enabled.
    issue_instr(32'h00500093, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 4'h0, 5'd1, 1'b1, 1'b0);
    in_instr = 32'h123452B7; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef ISSUE_PERF_CNT_EN
    check_eq("flush_perf_issued", perf_issued, 32'(exp_issued));
`endif
    @(posedge clk); #1;

    // Async reset in the middle of a stall.
    issue_instr(32'h409403B3, 32'h400, 32'd10, 32'd3, 32'h0, 32'd10, 32'd3, 4'h1, 5'd7, 1'b1, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
`ifdef ISSUE_PERF_CNT_EN
    check_eq("rst_perf_issued", perf_issued, 32'd0);
    check_eq("rst_perf_stall", perf_stall, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
